// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// UART_RX_PARITY_EN adds the PARITY state and the parity check helper.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_rx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } uart_rx_state_t;
`endif

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

`ifdef UART_RX_PARITY_EN
  // Data is zero-extended to 8 bits, which leaves its XOR reduction unchanged.
  function automatic logic parity_bad(input logic [7:0] data, input logic pbit, input logic odd);
    return ((^data) ^ pbit) != odd;
  endfunction
`endif

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; a write to a full FIFO is dropped and flagged
// as overrun unless the head is popped in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r, rptr_r;
  logic [AW:0]      count_r, count_n;
  logic             valid_r, ovr_r;
  logic             full_s, pop_s, push_s;

  assign full_s = (count_r == FULL_CNT);
  assign pop_s  = rd_en && valid_r;
  assign push_s = wr_en && (!full_s || pop_s);

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_n = count_r;
    case ({push_s, pop_s})
      2'b10:   count_n = count_r + CNT_ONE;
      2'b01:   count_n = count_r - CNT_ONE;
      default: count_n = count_r;
    endcase
  end

  // Storage array; no reset needed since reads are gated by rd_valid.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wptr_r] <= wr_data;
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      valid_r <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      if (push_s) wptr_r <= wptr_r + PTR_ONE;
      if (pop_s)  rptr_r <= rptr_r + PTR_ONE;
      count_r <= count_n;
      valid_r <= (count_n != '0);
      ovr_r   <= wr_en && full_s && !pop_s;
    end
  end

  assign rd_data  = mem_r[rptr_r];
  assign rd_valid = valid_r;
  assign count    = count_r;
  assign overrun  = ovr_r;

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority-vote bit decisions and a receive FIFO.
// Define UART_RX_PARITY_EN to receive and check one parity bit per frame.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          serial_in,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] MID_LO  = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] MID     = CW'(OVERSAMPLE/2);
  localparam logic [CW-1:0] MID_HI  = CW'(OVERSAMPLE/2 + 1);
  localparam logic [CW-1:0] LAST    = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  logic                 sync1_r, sync2_r, rx_prev_r;
  uart_rx_state_t       state_r, state_n;
  logic [CW-1:0]        cnt_r;
  logic [1:0]           samp_r;
  logic [IW-1:0]        bit_idx_r;
  logic                 stop_idx_r;
  logic [DATA_BITS-1:0] shreg_r;
  logic                 push_r, ferr_r, busy_r;
  logic                 bit_s, dec_s, end_s, bit_last_s, stop_last_s;
  logic                 shift_s, push_s, ferr_s;
`ifdef UART_RX_PARITY_EN
  logic                 perr_s, perr_r, par_bad_r;
`endif

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      sync1_r   <= serial_in;
      sync2_r   <= sync1_r;
      rx_prev_r <= sync2_r;
    end
  end

  // The third vote is the live sample, so the decision lands on MID_HI.
  assign bit_s       = maj3(samp_r[0], samp_r[1], sync2_r);
  assign dec_s       = (cnt_r == MID_HI);
  assign end_s       = (cnt_r == LAST);
  assign bit_last_s  = (bit_idx_r == IW'(DATA_BITS - 1));
  assign stop_last_s = (stop_idx_r == 1'(STOP_BITS - 1));

  // Next-state and per-cycle strobes.
  always_comb begin
    state_n = state_r;
    shift_s = 1'b0;
    push_s  = 1'b0;
    ferr_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_s  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (rx_prev_r && !sync2_r) state_n = ST_START;
        else                       state_n = ST_IDLE;
      end
      ST_START: begin
        if (dec_s && bit_s) state_n = ST_IDLE;
        else if (end_s)     state_n = ST_DATA;
        else                state_n = ST_START;
      end
      ST_DATA: begin
        shift_s = dec_s;
`ifdef UART_RX_PARITY_EN
        if (end_s && bit_last_s) state_n = ST_PARITY;
`else
        if (end_s && bit_last_s) state_n = ST_STOP;
`endif
        else                     state_n = ST_DATA;
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        perr_s = dec_s && parity_bad(8'(shreg_r), bit_s, 1'(PARITY_ODD));
        if (end_s) state_n = ST_STOP;
        else       state_n = ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (dec_s && !bit_s) begin
          ferr_s  = 1'b1;
          state_n = ST_IDLE;
        end else if (dec_s && stop_last_s) begin
`ifdef UART_RX_PARITY_EN
          push_s  = !par_bad_r;
`else
          push_s  = 1'b1;
`endif
          state_n = ST_IDLE;
        end else begin
          state_n = ST_STOP;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM state, bit timing, shift register and registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      samp_r     <= 2'b11;
      bit_idx_r  <= '0;
      stop_idx_r <= 1'b0;
      shreg_r    <= '0;
      push_r     <= 1'b0;
      ferr_r     <= 1'b0;
      busy_r     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_r     <= 1'b0;
      par_bad_r  <= 1'b0;
`endif
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n != ST_IDLE);
      push_r  <= push_s;
      ferr_r  <= ferr_s;
      if (state_r == ST_IDLE || end_s) cnt_r <= '0;
      else                             cnt_r <= cnt_r + CNT_ONE;
      if (cnt_r == MID_LO) samp_r[0] <= sync2_r;
      if (cnt_r == MID)    samp_r[1] <= sync2_r;
      if (state_r != ST_DATA) bit_idx_r <= '0;
      else if (end_s)         bit_idx_r <= bit_idx_r + IDX_ONE;
      if (state_r != ST_STOP) stop_idx_r <= 1'b0;
      else if (end_s)         stop_idx_r <= 1'b1;
      if (shift_s) shreg_r <= {bit_s, shreg_r[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
      perr_r <= perr_s;
      if (state_r == ST_IDLE) par_bad_r <= 1'b0;
      else if (perr_s)        par_bad_r <= 1'b1;
`endif
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (push_r),
    .wr_data  (shreg_r),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (fifo_count),
    .overrun  (overrun)
  );

  assign busy      = busy_r;
  assign frame_err = ferr_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule
